data_cache: RTL
===============

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter: INDEX_BITS, default 2, number of index bits; lines = 2^INDEX_BITS, 4 words per line, direct-mapped.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset_N  input  1  asynchronous, active-low reset.
REQ-004 d_readM  input  1  CPU read request, level, held until stall low.
REQ-005 d_writeM  input  1  CPU write request, level, held until stall low.
REQ-006 d_address  input  16  CPU word address: tag [15:2+INDEX_BITS], index, offset [1:0].
REQ-007 d_data  inout  16  CPU data; CPU drives on writes; cache drives only when d_readM=1 and d_stall=0, else high-Z.
REQ-008 d_stall  output  1  CPU must hold request and freeze while high.
REQ-009 m_readM  output  1  line fill request to memory.
REQ-010 m_writeM  output  1  line write-back request to memory.
REQ-011 m_address  output  16  line base address, offset bits [1:0]=0.
REQ-012 m_data  inout  64  line data, word 0 in [15:0]; cache drives only while m_writeM=1, else high-Z.
REQ-013 m_ready  input  1  one-cycle pulse: fill data valid on m_data, or write-back accepted.
REQ-014 hit_count  output  16  access-hit counter (see Configuration).
REQ-015 miss_count  output  16  access-miss counter (see Configuration).

Function
REQ-016 Hit: valid[index]=1 and tag match; evaluated combinationally each cycle.
REQ-017 Read hit: d_data = addressed word same cycle, d_stall=0, zero added latency.
REQ-018 Write hit: word written and dirty[index] set at the rising edge; d_stall=0.
REQ-019 Miss on a read or write: d_stall=1 combinationally in the same cycle; write-allocate policy.
REQ-020 FSM states: IDLE, WRITEBACK, FILL.
REQ-021 IDLE -> WRITEBACK on a miss with valid and dirty victim; IDLE -> FILL on a miss with clean or invalid victim.
REQ-022 WRITEBACK: m_writeM=1, m_address = {victim tag, index, 2'b00}, m_data = victim line; on m_ready -> FILL.
REQ-023 FILL: m_readM=1, m_address = {request tag, index, 2'b00}; on m_ready, capture m_data, set valid=1, dirty=0, tag; -> IDLE.
REQ-024 After FILL returns to IDLE, the held request hits; d_stall falls in that cycle. A write completes at that edge.
REQ-025 d_stall=1 in every cycle the FSM is in WRITEBACK or FILL.
REQ-026 m_readM and m_writeM are never high together.
REQ-027 No request, or both requests low: no state change and d_stall=0.
REQ-028 d_readM and d_writeM both high is treated as a write; d_data is not driven.
REQ-029 m_ready outside WRITEBACK or FILL is ignored.
REQ-030 Memory-side outputs are registered from FSM state; request address and data are sampled from held CPU inputs.

Reset
REQ-031 Reset_N low: FSM=IDLE; all valid and dirty bits cleared; m_readM=0, m_writeM=0, m_address=0; counters=0; d_stall follows REQ-019/025 from the IDLE state.
REQ-032 Reset mid-WRITEBACK or mid-FILL abandons the transfer immediately; no line is updated; a later m_ready is ignored.
REQ-033 Line data arrays need not be reset.

Configuration
REQ-034 Macro DCACHE_STATS_EN defined: hit_count increments on each access completing without a prior miss; miss_count increments once per miss, on the IDLE-exit edge; both wrap at 16'hFFFF.
REQ-035 Macro undefined: hit_count and miss_count ports remain and are driven constant 0; no counter registers are built.

Verification
REQ-036 Reset, then read 0x0014, memory model returns line {0x4444,0x3333,0x2222,0x1111} after 5 cycles -> d_stall high 7 cycles; m_readM with m_address=0x0014; d_data=0x1111; miss_count=1.
REQ-037 Read 0x0015 after REQ-036 -> d_stall=0, d_data=0x2222 same cycle; hit_count=1.
REQ-038 Write 0xBEEF to 0x0016, then read 0x0016 -> no stall on either access; read returns 0xBEEF; dirty set.
REQ-039 Read 0x0054 (same index, new tag) -> WRITEBACK first: m_writeM with m_address=0x0014 and m_data[47:32]=0xBEEF; then FILL at 0x0054; m_readM and m_writeM never high together.
REQ-040 Reset_N pulsed low during FILL, m_ready arriving afterwards -> FSM in IDLE, next read of 0x0014 misses, counters restart at 0.
REQ-041 Build without DCACHE_STATS_EN, run REQ-036..039 -> identical data behaviour; hit_count=miss_count=0 throughout.

Source files
------------

// File: rtl/data_cache_if.sv
// data_cache_if: CPU request/stall and memory handshake signals of the data cache.
interface data_cache_if;
  logic        d_readM;
  logic        d_writeM;
  logic [15:0] d_address;
  logic        d_stall;
  logic        m_readM;
  logic        m_writeM;
  logic [15:0] m_address;
  logic        m_ready;
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  modport slave (
    input  d_readM, d_writeM, d_address, m_ready,
    output d_stall, m_readM, m_writeM, m_address, hit_count, miss_count
  );
  modport master (
    output d_readM, d_writeM, d_address, m_ready,
    input  d_stall, m_readM, m_writeM, m_address, hit_count, miss_count
  );
endinterface

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate cache of 4-word lines.
// Define DCACHE_STATS_EN to build the hit/miss counters; otherwise they read 0.
module data_cache #(
  parameter int INDEX_BITS = 2
) (
  input  logic        Clk,
  input  logic        Reset_N,
  data_cache_if.slave bus,
  inout  wire  [15:0] d_data,
  inout  wire  [63:0] m_data
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 14 - INDEX_BITS;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;
  state_t                  state_q, state_d;
  logic [15:0]             data_q [LINES][4];
  logic [TAG_W-1:0]        tag_q [LINES];
  logic [LINES-1:0]        valid_q, dirty_q;
  logic                    m_readM_q, m_readM_d, m_writeM_q, m_writeM_d;
  logic [15:0]             m_address_q, m_address_d;
  logic [INDEX_BITS-1:0]   idx;
  logic [TAG_W-1:0]        tag;
  logic [1:0]              off;
  logic                    req, hit, miss, idle, stall, do_write, fill_done;
  assign idx       = bus.d_address[2 +: INDEX_BITS];
  assign tag       = bus.d_address[15 -: TAG_W];
  assign off       = bus.d_address[1:0];
  assign req       = bus.d_readM | bus.d_writeM;
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign miss      = req && !hit;
  assign idle      = state_q == IDLE;
  assign stall     = !idle || miss;
  assign do_write  = idle && bus.d_writeM && hit;
  assign fill_done = (state_q == FILL) && bus.m_ready;
  assign bus.d_stall   = stall;
  assign bus.m_readM   = m_readM_q;
  assign bus.m_writeM  = m_writeM_q;
  assign bus.m_address = m_address_q;
  // Both requests high is a write, so the cache never fights the CPU on d_data.
  assign d_data = (bus.d_readM && !bus.d_writeM && !stall) ? data_q[idx][off] : 'z;
  assign m_data = m_writeM_q ? {data_q[idx][3], data_q[idx][2], data_q[idx][1], data_q[idx][0]} : 'z;
  always_comb begin
    state_d     = state_q;
    m_readM_d   = m_readM_q;
    m_writeM_d  = m_writeM_q;
    m_address_d = m_address_q;
    case (state_q)
      IDLE: if (miss) begin
        state_d     = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FILL;
        m_writeM_d  = valid_q[idx] && dirty_q[idx];
        m_readM_d   = !(valid_q[idx] && dirty_q[idx]);
        m_address_d = (valid_q[idx] && dirty_q[idx]) ? {tag_q[idx], idx, 2'b00} : {tag, idx, 2'b00};
      end
      WRITEBACK: if (bus.m_ready) begin
        state_d     = FILL;
        m_writeM_d  = 1'b0;
        m_readM_d   = 1'b1;
        m_address_d = {tag, idx, 2'b00};
      end
      FILL: if (bus.m_ready) begin
        state_d   = IDLE;
        m_readM_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      m_readM_q   <= 1'b0;
      m_writeM_q  <= 1'b0;
      m_address_q <= '0;
    end else begin
      state_q     <= state_d;
      m_readM_q   <= m_readM_d;
      m_writeM_q  <= m_writeM_d;
      m_address_q <= m_address_d;
      if (fill_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (do_write) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end
  // Line storage is not reset; valid bits alone gate its use.
  always_ff @(posedge Clk) begin
    if (fill_done) begin
      tag_q[idx] <= tag;
      for (int w = 0; w < 4; w++) data_q[idx][w] <= m_data[16*w +: 16];
    end else if (do_write) begin
      data_q[idx][off] <= d_data;
    end
  end
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_q, miss_q;
  logic        missed_q;
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      hit_q    <= '0;
      miss_q   <= '0;
      missed_q <= 1'b0;
    end else if (idle && miss) begin
      miss_q   <= miss_q + 16'd1;
      missed_q <= 1'b1;
    end else if (idle && req) begin
      hit_q    <= missed_q ? hit_q : hit_q + 16'd1;
      missed_q <= 1'b0;
    end
  end
  assign bus.hit_count  = hit_q;
  assign bus.miss_count = miss_q;
`else
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
`endif
endmodule
